uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among `N_REQ` byte requesters. It sits between the requesters and the transmitter's `tx_req`/`tx_data`/`comp`/`stop_sel`/`tr_en`/`tx_req_ack` interface. It grants one requester at a time, issues a single transmit request, and waits for the frame-complete acknowledge. A watchdog recovers the arbiter if the acknowledge never arrives.

## Interface
- `N_REQ`, 4 — number of requesters, 2..8.
- `TIMEOUT`, 65535 — maximum BUSY cycles (with `tr_en` high) to wait for `tx_req_ack`; range 32..2^20-1.
- `clk` input 1 — clock.
- `resetn` input 1 — reset, asynchronous and active-low.
- `tr_en_i` input 1 — global enable; gates new grants and the watchdog.
- `req` input N_REQ — per-requester level request; held with its data until the matching `done` bit.
- `req_data` input N_REQ*8 — byte of requester i at bits [8i+7:8i].
- `cfg_comp` input 16 — baud divider, sampled at grant.
- `cfg_stop_sel` input 2 — stop-bit select, sampled at grant.
- `tx_req` output 1 — one-cycle transmit request to the transmitter.
- `tx_data` output 8 — latched byte.
- `comp` output 16 — latched divider.
- `stop_sel` output 2 — latched stop select.
- `tr_en` output 1 — registered copy of `tr_en_i`.
- `tx_req_ack` input 1 — one-cycle frame-complete pulse from the transmitter.
- `done` output N_REQ — one-hot, one-cycle completion pulse to the granted requester.
- `timeout_err` output 1 — one-cycle pulse when the watchdog expires.
- `grant_id` output $clog2(N_REQ) — index of the current or last granted requester.
- `busy` output 1 — high in ISSUE and BUSY.

## Operation
- Reset values: `tx_req`=0, `tx_data`=0, `comp`=0, `stop_sel`=0, `tr_en`=0, `done`=0, `timeout_err`=0, `grant_id`=N_REQ-1, `busy`=0, state IDLE, watchdog=0.
- States: IDLE, ISSUE, BUSY.
- IDLE → ISSUE: requires `tr_en` high and `req` nonzero.
  - Winner is the first set bit searching upward from `grant_id`+1, wrapping modulo N_REQ.
  - The same edge latches `grant_id`, `tx_data` from the winner's slice, `comp`, and `stop_sel`.
- ISSUE → BUSY: unconditional after one cycle. `tx_req` is high only while in ISSUE. The watchdog clears on entry to BUSY.
- BUSY → IDLE on `tx_req_ack`: `done[grant_id]` pulses for one cycle coincident with the IDLE entry.
- BUSY → IDLE on watchdog reaching TIMEOUT: `timeout_err` pulses for one cycle. `done` is not pulsed. The requester stays pending and competes again, and the pointer has already advanced.
- Watchdog increments only in BUSY with `tr_en` high. It holds while `tr_en` is low.
- `tr_en` low in IDLE: no grant is issued. Low in ISSUE or BUSY: the sequence continues, and `tx_req` still fires in ISSUE.
- `tx_req_ack` outside BUSY: ignored.
- `tx_req_ack` and watchdog expiry in the same cycle: the ack wins, so `done` pulses and `timeout_err` stays 0.
- A requester dropping `req` while granted: the frame completes and `done` still pulses.
- `req` bits and `req_data` changing while not granted: no effect.
- `cfg_*` changes mid-frame: no effect until the next grant.
- Reset mid-operation: immediate return to reset values. The in-flight frame is abandoned and no `done` is produced.

## Timing
- Request visible in IDLE at edge t: ISSUE from t+1 (`tx_req`=1, `tx_data` valid), BUSY from t+2.
- Ack sampled at edge a: `done` high during cycle a+1, IDLE from a+1. The earliest next `tx_req` is at a+2.
- Back-to-back pending requesters produce one transmit per acknowledge with a 2-cycle ack-to-request gap.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `uart_tx_arb_pkg`:
  - state enum `arb_state_t` {IDLE, ISSUE, BUSY};
  - default constants `ARB_N_REQ_DEF`=4 and `ARB_TIMEOUT_DEF`=65535.
- Sub-module `uart_rr_pick`: combinational round-robin picker. Inputs are `req` and the last grant index. Outputs are `valid` and the winner index. It is reused by other shared-resource schedulers.
- Watchdog width is $clog2(TIMEOUT+1).

## Test plan
- Single request: `req`=4'b0010, `req_data[15:8]`=8'hA5, `cfg_comp`=16'd27 → `tx_req` pulse 1 cycle later with `tx_data`=8'hA5, `comp`=27, `grant_id`=1. Ack → `done`=4'b0010 for one cycle.
- Fairness: `req`=4'b1111 held, ack 20 cycles after each `tx_req` → grant order 0,1,2,3,0. Each ack-to-next-`tx_req` gap is exactly 2 cycles.
- Enable gating: `tr_en_i`=0 with `req`=4'b0001 → no `tx_req` for 100 cycles. Raise `tr_en_i` → `tx_req` 2 cycles later (1 cycle for the `tr_en` register, 1 cycle for the grant).
- Timeout: `TIMEOUT`=32, no ack → `timeout_err` pulse exactly 32 `tr_en`-high BUSY cycles after entry, `done`=0. Next `tx_req` goes to the next pending requester.
- Ack/timeout collision: ack on the expiry cycle → `done` pulses and `timeout_err`=0.
- Reset mid-BUSY: `resetn` low → all outputs return to reset values asynchronously, with no `done`. After release with `req`=4'b0001 → requester 0 is granted first.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and default parameters for the UART transmit arbiter slice.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  localparam int unsigned ARB_N_REQ_DEF   = 4;
  localparam int unsigned ARB_TIMEOUT_DEF = 65535;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last+1, wrapping.
module uart_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ = ARB_N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int unsigned IW = $clog2(N_REQ);

  logic [IW-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IW'((32'(last) + k) % N_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte requesters,
// with a watchdog that recovers when the frame-complete acknowledge never arrives.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = ARB_N_REQ_DEF,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     tr_en_i,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*8-1:0]       req_data,
  input  logic [15:0]              cfg_comp,
  input  logic [1:0]               cfg_stop_sel,
  output logic                     tx_req,
  output logic [7:0]               tx_data,
  output logic [15:0]              comp,
  output logic [1:0]               stop_sel,
  output logic                     tr_en,
  input  logic                     tx_req_ack,
  output logic [N_REQ-1:0]         done,
  output logic                     timeout_err,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int unsigned IW  = $clog2(N_REQ);
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_BUSY  = BUSY;

  logic [1:0]       state_q, state_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [IW-1:0]    grant_d;
  logic [7:0]       tx_data_d;
  logic [15:0]      comp_d;
  logic [1:0]       stop_d;
  logic [N_REQ-1:0] done_d;
  logic             terr_d;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .last  (grant_id),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state and next-output logic; everything below is registered.
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    grant_d   = grant_id;
    tx_data_d = tx_data;
    comp_d    = comp;
    stop_d    = stop_sel;
    done_d    = '0;
    terr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tr_en && pick_valid) begin
          state_d   = ST_ISSUE;
          grant_d   = pick_idx;
          tx_data_d = req_data[{pick_idx, 3'b000} +: 8];
          comp_d    = cfg_comp;
          stop_d    = cfg_stop_sel;
        end
      end
      ST_ISSUE: begin
        state_d = ST_BUSY;
        wd_d    = '0;
      end
      ST_BUSY: begin
        // Ack takes priority over a coincident watchdog expiry.
        if (tx_req_ack) begin
          state_d          = ST_IDLE;
          done_d[grant_id] = 1'b1;
        end else if (tr_en) begin
          if (wd_q == WDW'(TIMEOUT - 1)) begin
            state_d = ST_IDLE;
            terr_d  = 1'b1;
          end else begin
            wd_d = wd_q + WDW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      wd_q        <= '0;
      tx_req      <= 1'b0;
      tx_data     <= '0;
      comp        <= '0;
      stop_sel    <= '0;
      tr_en       <= 1'b0;
      done        <= '0;
      timeout_err <= 1'b0;
      grant_id    <= IW'(N_REQ - 1);
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      tx_req      <= (state_d == ST_ISSUE);
      tx_data     <= tx_data_d;
      comp        <= comp_d;
      stop_sel    <= stop_d;
      tr_en       <= tr_en_i;
      done        <= done_d;
      timeout_err <= terr_d;
      grant_id    <= grant_d;
      busy        <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a randomized run against a queue-level model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        resetn, tr_en_i, tx_req_ack;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [15:0] cfg_comp;
  logic [1:0]  cfg_stop_sel;
  logic        tx_req, tr_en, timeout_err, busy;
  logic [7:0]  tx_data;
  logic [15:0] comp;
  logic [1:0]  stop_sel;
  logic [3:0]  done;
  logic [1:0]  grant_id;

  int vec  = 0;
  int miss = 0;

  localparam logic [33:0] RESET_VEC = {1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 4'b0000, 1'b0, 2'd3};

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .tr_en_i(tr_en_i), .req(req), .req_data(req_data),
    .cfg_comp(cfg_comp), .cfg_stop_sel(cfg_stop_sel), .tx_req(tx_req), .tx_data(tx_data),
    .comp(comp), .stop_sel(stop_sel), .tr_en(tr_en), .tx_req_ack(tx_req_ack), .done(done),
    .timeout_err(timeout_err), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int max, output int n);
    n = 0;
    while (tx_req !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic apply_reset();
    resetn = 1'b0; tr_en_i = 1'b0; tx_req_ack = 1'b0; req = '0;
    req_data = '0; cfg_comp = '0; cfg_stop_sel = '0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    vec++;
    if ({tx_req, tx_data, comp, stop_sel, tr_en, done, timeout_err, grant_id} !== RESET_VEC) begin
      miss++;
      $display("FAIL reset_outputs: got %h expected %h",
               {tx_req, tx_data, comp, stop_sel, tr_en, done, timeout_err, grant_id}, RESET_VEC);
    end
    vec++;
    if (busy !== 1'b0) begin miss++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    int n;
    tr_en_i = 1'b1;
    tick();
    req = 4'b0010; req_data[15:8] = 8'hA5; cfg_comp = 16'd27; cfg_stop_sel = 2'd2;
    wait_tx(8, n);
    vec++; if (n !== 1) begin miss++; $display("FAIL single_latency: got %0d expected 1", n); end
    vec++; if (tx_data !== 8'hA5) begin miss++; $display("FAIL single_data: got %h expected a5", tx_data); end
    vec++; if (comp !== 16'd27 || stop_sel !== 2'd2) begin
      miss++; $display("FAIL single_cfg: got %0d/%0d expected 27/2", comp, stop_sel); end
    vec++; if (grant_id !== 2'd1) begin miss++; $display("FAIL single_grant: got %0d expected 1", grant_id); end
    tick();
    vec++; if (tx_req !== 1'b0 || busy !== 1'b1) begin
      miss++; $display("FAIL single_pulse: got tx_req=%b busy=%b expected 0/1", tx_req, busy); end
    repeat (3) tick();
    tx_req_ack = 1'b1;
    tick();
    tx_req_ack = 1'b0; req = '0;
    vec++; if (done !== 4'b0010 || busy !== 1'b0) begin
      miss++; $display("FAIL single_done: got done=%b busy=%b expected 0010/0", done, busy); end
    tick();
    vec++; if (done !== 4'b0000) begin miss++; $display("FAIL single_done_clear: got %b expected 0000", done); end
    tx_req_ack = 1'b1;
    tick();
    tx_req_ack = 1'b0;
    tick();
    vec++; if (done !== 4'b0000 || busy !== 1'b0) begin
      miss++; $display("FAIL idle_ack_ignored: got done=%b busy=%b expected 0000/0", done, busy); end
  endtask

  task automatic test_fairness();
    int n;
    int g;
    apply_reset();
    tr_en_i = 1'b1; req = 4'b1111; req_data = $urandom;
    for (int k = 0; k < 5; k++) begin
      g = k % N;
      wait_tx(8, n);
      vec++; if (grant_id !== 2'(g) || tx_data !== req_data[8*g +: 8]) begin
        miss++; $display("FAIL fair_grant: got id=%0d data=%h expected id=%0d data=%h",
                         grant_id, tx_data, g, req_data[8*g +: 8]); end
      if (k > 0) begin
        vec++; if (n + 1 !== 2) begin miss++; $display("FAIL fair_gap: got %0d expected 2", n + 1); end
      end
      repeat (19) tick();
      tx_req_ack = 1'b1;
      tick();
      tx_req_ack = 1'b0;
      if (k == 4) req = '0;
      vec++; if (done !== 4'(1 << g)) begin
        miss++; $display("FAIL fair_done: got %b expected %b", done, 4'(1 << g)); end
    end
    tick();
  endtask

  task automatic test_enable();
    int n;
    bit seen;
    apply_reset();
    req = 4'b0001; seen = 1'b0;
    repeat (100) begin
      tick();
      if (tx_req === 1'b1) seen = 1'b1;
    end
    vec++; if (seen !== 1'b0) begin miss++; $display("FAIL enable_gate: got tx_req seen=%b expected 0", seen); end
    tr_en_i = 1'b1;
    wait_tx(8, n);
    vec++; if (n !== 2) begin miss++; $display("FAIL enable_latency: got %0d expected 2", n); end
    tick();
    tx_req_ack = 1'b1;
    tick();
    tx_req_ack = 1'b0; req = '0;
    vec++; if (done !== 4'b0001) begin miss++; $display("FAIL enable_done: got %b expected 0001", done); end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    int cnt;
    apply_reset();
    tr_en_i = 1'b1; req = 4'b0011; req_data = 32'h0000_3C5A;
    wait_tx(8, n);
    vec++; if (grant_id !== 2'd0) begin miss++; $display("FAIL to_first_grant: got %0d expected 0", grant_id); end
    tick();
    cnt = 0;
    while (timeout_err !== 1'b1 && cnt < 100) begin tick(); cnt++; end
    vec++; if (cnt !== TO) begin miss++; $display("FAIL to_cycles: got %0d expected %0d", cnt, TO); end
    vec++; if (done !== 4'b0000 || busy !== 1'b0) begin
      miss++; $display("FAIL to_no_done: got done=%b busy=%b expected 0000/0", done, busy); end
    wait_tx(8, n);
    vec++; if (n !== 1 || grant_id !== 2'd1 || tx_data !== 8'h3C) begin
      miss++; $display("FAIL to_next_grant: got n=%0d id=%0d data=%h expected 1/1/3c", n, grant_id, tx_data); end
    // Watchdog must hold while tr_en is low for five cycles.
    tick();
    cnt = 0;
    repeat (10) begin tick(); cnt++; end
    tr_en_i = 1'b0;
    repeat (5) begin tick(); cnt++; end
    tr_en_i = 1'b1;
    while (timeout_err !== 1'b1 && cnt < 100) begin tick(); cnt++; end
    vec++; if (cnt !== TO + 5) begin miss++; $display("FAIL to_hold: got %0d expected %0d", cnt, TO + 5); end
    wait_tx(8, n);
    vec++; if (grant_id !== 2'd0) begin miss++; $display("FAIL to_regrant: got %0d expected 0", grant_id); end
    tick();
    repeat (TO - 1) tick();
    tx_req_ack = 1'b1;
    tick();
    tx_req_ack = 1'b0; req = 4'b0010;
    vec++; if (done !== 4'b0001 || timeout_err !== 1'b0) begin
      miss++; $display("FAIL to_collision: got done=%b terr=%b expected 0001/0", done, timeout_err); end
    wait_tx(8, n);
    tick();
    tx_req_ack = 1'b1;
    tick();
    tx_req_ack = 1'b0; req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    apply_reset();
    tr_en_i = 1'b1; req = 4'b0100; req_data = 32'h00EE_0000; cfg_comp = 16'h1234;
    wait_tx(8, n);
    repeat (4) tick();
    #2;
    resetn = 1'b0; tx_req_ack = 1'b1;
    #1;
    vec++;
    if ({tx_req, tx_data, comp, stop_sel, tr_en, done, timeout_err, grant_id} !== RESET_VEC || busy !== 1'b0) begin
      miss++;
      $display("FAIL reset_mid_async: got %h busy=%b expected %h busy=0",
               {tx_req, tx_data, comp, stop_sel, tr_en, done, timeout_err, grant_id}, busy, RESET_VEC);
    end
    @(posedge clk);
    #1;
    vec++; if (done !== 4'b0000) begin miss++; $display("FAIL reset_mid_done: got %b expected 0000", done); end
    tx_req_ack = 1'b0; resetn = 1'b1; req = 4'b0101;
    wait_tx(8, n);
    vec++; if (tx_req !== 1'b1 || grant_id !== 2'd0) begin
      miss++; $display("FAIL reset_mid_regrant: got tx_req=%b id=%0d expected 1/0", tx_req, grant_id); end
    apply_reset();
  endtask

  task automatic test_random();
    logic [3:0] pend;
    logic [7:0] dat [4];
    logic [15:0] cc;
    logic [1:0]  cs;
    int last, w, n, d, j;
    apply_reset();
    tr_en_i = 1'b1;
    tick();
    pend = '0; last = N - 1;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom % 2) == 1) begin
          pend[i] = 1'b1; dat[i] = 8'($urandom);
        end
      end
      if (pend == '0) begin
        j = int'($urandom % N); pend[j] = 1'b1; dat[j] = 8'($urandom);
      end
      for (int i = 0; i < N; i++) req_data[8*i +: 8] = pend[i] ? dat[i] : 8'($urandom);
      req = pend;
      cc = 16'($urandom); cs = 2'($urandom);
      cfg_comp = cc; cfg_stop_sel = cs;
      w = -1;
      for (int k = 1; k <= N; k++) begin
        j = (last + k) % N;
        if (w < 0 && pend[j]) w = j;
      end
      wait_tx(8, n);
      vec++; if (n !== 1 || grant_id !== 2'(w) || tx_data !== dat[w] || comp !== cc || stop_sel !== cs) begin
        miss++; $display("FAIL rand_grant it=%0d: got n=%0d id=%0d data=%h comp=%h stop=%0d expected 1/%0d/%h/%h/%0d",
                         it, n, grant_id, tx_data, comp, stop_sel, w, dat[w], cc, cs); end
      last = w;
      cfg_comp = 16'($urandom); cfg_stop_sel = 2'($urandom);
      tick();
      d = int'($urandom_range(1, 40));
      if (d <= TO) begin
        repeat (d - 1) tick();
        if (($urandom % 4) == 0) req[w] = 1'b0;
        tx_req_ack = 1'b1;
        tick();
        tx_req_ack = 1'b0;
        vec++; if (done !== 4'(1 << w) || timeout_err !== 1'b0 || comp !== cc) begin
          miss++; $display("FAIL rand_done it=%0d: got done=%b terr=%b comp=%h expected %b/0/%h",
                           it, done, timeout_err, comp, 4'(1 << w), cc); end
        pend[w] = 1'b0; req[w] = 1'b0;
      end else begin
        repeat (TO - 1) tick();
        vec++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin
          miss++; $display("FAIL rand_early_to it=%0d: got terr=%b busy=%b expected 0/1", it, timeout_err, busy); end
        tick();
        vec++; if (timeout_err !== 1'b1 || done !== 4'b0000) begin
          miss++; $display("FAIL rand_timeout it=%0d: got terr=%b done=%b expected 1/0000", it, timeout_err, done); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_enable();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
